// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO. While entries are queued, frames go out
// back-to-back with no idle gap between them.
module uart_tx_fifo #(
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        sys_clk,
    input  logic                        uart_reset,
    input  logic                        tx_valid,
    input  logic [DATA_BITS-1:0]        tx_data,
    output logic                        tx_ready,
    output logic                        TxD,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(CLK_DIV);
    localparam int unsigned NW = 3;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t                 state_q, state_d;
    logic [BW-1:0]          baud_q, baud_d;
    logic [NW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   par_q, par_d;
    logic                   txd_d, busy_d, done_d;
    logic                   bit_end, start_frame, push, pop;
    logic [CW-1:0]          count_d;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0]   head;

    assign push    = tx_valid && tx_ready;
    assign head    = mem[rd_ptr];
    assign bit_end = (baud_q == BW'(CLK_DIV - 1));

    // Next-state and next-output logic for the transmit sequencer.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_d       = par_q;
        txd_d       = TxD;
        busy_d      = busy;
        done_d      = 1'b0;
        start_frame = 1'b0;
        pop         = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BW'(1);
        end

        case (state_q)
            S_IDLE: begin
                start_frame = (fifo_count != '0);
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == NW'(DATA_BITS - 1)) begin
                        if (PARITY != 0) begin
                            state_d = S_PAR;
                            txd_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                            bit_d   = '0;
                        end
                    end else begin
                        txd_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + NW'(1);
                    end
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (bit_q == NW'(STOP_BITS - 1)) begin
                    // Registered one cycle early so done covers the final stop cycle.
                    done_d = (baud_q == BW'(CLK_DIV - 2));
                    if (bit_end) begin
                        if (fifo_count != '0) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            txd_d   = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end
                end else if (bit_end) begin
                    bit_d = bit_q + NW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (start_frame) begin
            pop     = 1'b1;
            state_d = S_START;
            baud_d  = '0;
            txd_d   = 1'b0;
            busy_d  = 1'b1;
            shift_d = head;
            par_d   = (PARITY == 1) ? ~^head : ^head;
        end
    end

    assign count_d = fifo_count + CW'(push) - CW'(pop);

    // State, counters, FIFO pointers and registered outputs.
    always_ff @(posedge sys_clk or posedge uart_reset) begin
        if (uart_reset) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            TxD        <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            fifo_count <= '0;
            tx_ready   <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            TxD        <= txd_d;
            busy       <= busy_d;
            done       <= done_d;
            fifo_count <= count_d;
            tx_ready   <= (count_d != CW'(FIFO_DEPTH));
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Storage needs no reset; occupancy is tracked by fifo_count.
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four framing configurations driven in parallel and
// compared every cycle against a queue-and-frame reference model.
module tb_uart_tx_fifo;
    localparam int NDUT  = 4;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;

    logic       sys_clk = 1'b0;
    logic       uart_reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       txd_w   [NDUT];
    logic       busy_w  [NDUT];
    logic       done_w  [NDUT];
    logic       ready_w [NDUT];
    logic [2:0] cnt_w   [NDUT];

    always #5 sys_clk = ~sys_clk;

    uart_tx_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8n1 (
        .sys_clk(sys_clk), .uart_reset(uart_reset), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(ready_w[0]), .TxD(txd_w[0]), .busy(busy_w[0]), .done(done_w[0]), .fifo_count(cnt_w[0]));
    uart_tx_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8e1 (
        .sys_clk(sys_clk), .uart_reset(uart_reset), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(ready_w[1]), .TxD(txd_w[1]), .busy(busy_w[1]), .done(done_w[1]), .fifo_count(cnt_w[1]));
    uart_tx_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8o1 (
        .sys_clk(sys_clk), .uart_reset(uart_reset), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(ready_w[2]), .TxD(txd_w[2]), .busy(busy_w[2]), .done(done_w[2]), .fifo_count(cnt_w[2]));
    uart_tx_fifo #(.CLK_DIV(DIV), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_5n2 (
        .sys_clk(sys_clk), .uart_reset(uart_reset), .tx_valid(tx_valid), .tx_data(tx_data[4:0]),
        .tx_ready(ready_w[3]), .TxD(txd_w[3]), .busy(busy_w[3]), .done(done_w[3]), .fifo_count(cnt_w[3]));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int cfg_dbits(input int i);
        return (i == 3) ? 5 : 8;
    endfunction
    function automatic int cfg_par(input int i);
        return (i == 1) ? 2 : (i == 2) ? 1 : 0;
    endfunction
    function automatic int cfg_stops(input int i);
        return (i == 3) ? 2 : 1;
    endfunction
    function automatic int frame_len(input int i);
        return (1 + cfg_dbits(i) + ((cfg_par(i) != 0) ? 1 : 0) + cfg_stops(i)) * DIV;
    endfunction

    // Line level of bit k of the frame carrying word (start, data LSB-first, parity, stops).
    function automatic int frame_bit(input int i, input int word, input int k);
        int db;
        int ones;
        db = cfg_dbits(i);
        if (k == 0) return 0;
        if (k <= db) return (word >> (k - 1)) & 1;
        if (cfg_par(i) != 0 && k == db + 1) begin
            ones = $countones(word);
            return (cfg_par(i) == 2) ? (ones % 2) : (1 - ones % 2);
        end
        return 1;
    endfunction

    // Reference model: FIFO contents as a queue, plus the word on the line and cycles elapsed.
    int mq     [NDUT][$];
    int m_word [NDUT];
    int m_t    [NDUT];

    task automatic model_step();
        int size_pre;
        for (int i = 0; i < NDUT; i++) begin
            if (uart_reset) begin
                mq[i].delete();
                m_t[i] = -1;
            end else begin
                size_pre = mq[i].size();
                if (m_t[i] >= 0) m_t[i]++;
                if (m_t[i] < 0 || m_t[i] == frame_len(i)) begin
                    if (size_pre > 0) begin
                        m_word[i] = mq[i].pop_front();
                        m_t[i]    = 0;
                    end else begin
                        m_t[i] = -1;
                    end
                end
                if (tx_valid && size_pre != DEPTH)
                    mq[i].push_back(int'(tx_data) & ((1 << cfg_dbits(i)) - 1));
            end
        end
    endtask

    task automatic check_all();
        int e_txd;
        int e_busy;
        int e_done;
        for (int i = 0; i < NDUT; i++) begin
            if (m_t[i] >= 0) begin
                e_txd  = frame_bit(i, m_word[i], m_t[i] / DIV);
                e_busy = 1;
                e_done = (m_t[i] == frame_len(i) - 1) ? 1 : 0;
            end else begin
                e_txd  = 1;
                e_busy = 0;
                e_done = 0;
            end
            check($sformatf("txd%0d", i),   int'(txd_w[i]),  e_txd);
            check($sformatf("busy%0d", i),  int'(busy_w[i]), e_busy);
            check($sformatf("done%0d", i),  int'(done_w[i]), e_done);
            check($sformatf("count%0d", i), int'(cnt_w[i]),  mq[i].size());
            check($sformatf("ready%0d", i), int'(ready_w[i]), (mq[i].size() != DEPTH) ? 1 : 0);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        check_all();
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("%s_txd%0d", tag, i),   int'(txd_w[i]),   1);
            check($sformatf("%s_busy%0d", tag, i),  int'(busy_w[i]),  0);
            check($sformatf("%s_done%0d", tag, i),  int'(done_w[i]),  0);
            check($sformatf("%s_count%0d", tag, i), int'(cnt_w[i]),   0);
            check($sformatf("%s_ready%0d", tag, i), int'(ready_w[i]), 1);
        end
    endtask

    int cap_txd  [NDUT][64];
    int cap_busy [NDUT][64];
    int done_at  [NDUT];
    int done_n   [NDUT];

    // Queue one word, then record ncyc cycles; cycle 1 is the first cycle of the frame.
    task automatic send_and_capture(input logic [7:0] d, input int ncyc);
        tx_valid = 1'b1;
        tx_data  = d;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            done_at[i] = 0;
            done_n[i]  = 0;
        end
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            for (int i = 0; i < NDUT; i++) begin
                cap_txd[i][c]  = int'(txd_w[i]);
                cap_busy[i][c] = int'(busy_w[i]);
                if (done_w[i]) begin
                    done_n[i]++;
                    if (done_at[i] == 0) done_at[i] = c;
                end
            end
        end
    endtask

    int exp_a5 [10]        = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int burst_cnt_exp [6]  = '{1, 1, 2, 3, 4, 4};
    int dn;
    int gaps;
    int rate;

    initial begin
        uart_reset = 1'b1;
        tx_valid   = 1'b0;
        tx_data    = '0;
        for (int i = 0; i < NDUT; i++) begin
            m_t[i]    = -1;
            m_word[i] = 0;
        end
        tick();
        tick();
        check_reset_state("por");

        // Write on the first edge after release; 8N1 0xA5 waveform.
        uart_reset = 1'b0;
        send_and_capture(8'hA5, 50);
        for (int k = 0; k < 10; k++)
            check($sformatf("a5_bit%0d", k), cap_txd[0][k * DIV + 2], exp_a5[k]);
        check("a5_done_at", done_at[0], 40);
        check("a5_done_n", done_n[0], 1);
        check("a5_busy_last", cap_busy[0][40], 1);
        check("a5_busy_fall", cap_busy[0][41], 0);

        // Parity of 0x07 in even and odd modes.
        send_and_capture(8'h07, 50);
        check("even_par_bit", cap_txd[1][9 * DIV + 2], 1);
        check("odd_par_bit", cap_txd[2][9 * DIV + 2], 0);
        check("even_len", done_at[1], 44);
        check("odd_len", done_at[2], 44);

        // Five data bits, two stop bits.
        send_and_capture(8'h1F, 50);
        for (int k = 0; k < 8; k++)
            check($sformatf("5n2_bit%0d", k), cap_txd[3][k * DIV + 2], (k == 0) ? 0 : 1);
        check("5n2_len", done_at[3], 32);

        // Six back-to-back writes from idle into a four-entry FIFO.
        for (int k = 0; k < 6; k++) begin
            if (k == 5) check("burst_ready6", int'(ready_w[0]), 0);
            tx_valid = 1'b1;
            tx_data  = 8'h10 + 8'(k);
            tick();
            check($sformatf("burst_cnt%0d", k), int'(cnt_w[0]), burst_cnt_exp[k]);
        end
        tx_valid = 1'b0;
        dn   = 0;
        gaps = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (done_w[0]) dn++;
            if (!busy_w[0] && dn < 5) gaps++;
        end
        check("burst_frames", dn, 5);
        check("burst_gaps", gaps, 0);
        repeat (60) tick();

        // Reset in the middle of the second of three queued frames.
        for (int k = 0; k < 3; k++) begin
            tx_valid = 1'b1;
            tx_data  = 8'($urandom);
            tick();
        end
        tx_valid = 1'b0;
        repeat (58) tick();
        check("pre_rst_busy", int'(busy_w[0]), 1);
        uart_reset = 1'b1;
        #1;
        check_reset_state("async");
        tick();
        tick();
        uart_reset = 1'b0;
        dn   = 0;
        gaps = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            for (int i = 0; i < NDUT; i++) begin
                if (done_w[i]) dn++;
                if (busy_w[i]) gaps++;
            end
        end
        check("post_rst_done", dn, 0);
        check("post_rst_busy", gaps, 0);
        send_and_capture(8'h3C, 50);
        check("post_rst_len", done_at[0], 40);
        check("post_rst_bit3", cap_txd[0][3 * DIV + 2], 1);

        // Randomized traffic at several write rates with occasional resets.
        for (int seg = 0; seg < 6; seg++) begin
            rate = (seg % 3 == 0) ? 10 : (seg % 3 == 1) ? 40 : 95;
            for (int c = 0; c < 300; c++) begin
                tx_valid   = ($urandom_range(99) < rate);
                tx_data    = 8'($urandom);
                uart_reset = ($urandom_range(599) == 0);
                tick();
            end
        end
        uart_reset = 1'b0;
        tx_valid   = 1'b0;
        repeat (300) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
